// File: rtl/ysyx_25020047_pkg.sv
// Shared encodings for the LSU: access sizes, FSM states and strobe base patterns.
package ysyx_25020047_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module ysyx_25020047_lsu_align
  import ysyx_25020047_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_lane_data,
  output logic [3:0]  st_wstrb,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_lane_data = st_wdata;
    st_wstrb     = STRB_W;
    case (st_size)
      SZ_B: begin
        st_lane_data = {4{st_wdata[7:0]}};
        st_wstrb     = STRB_B << st_off;
      end
      SZ_H: begin
        st_lane_data = {2{st_wdata[15:0]}};
        st_wstrb     = STRB_H << st_off;
      end
      default: begin
        st_lane_data = st_wdata;
        st_wstrb     = STRB_W;
      end
    endcase
  end

  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    ld_data    = ld_rdata;
    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H:    ld_data = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: one outstanding data-memory transaction over valid/ready, then write-back.
module ysyx_25020047_lsu
  import ysyx_25020047_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_result,
  input  logic            in_read,
  input  logic            in_write,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [DW-1:0]   in_wdata,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_wen,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wstrb,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_resp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_misalign
);

  lsu_state_e  state_q, state_d;
  logic        accept, is_mem, misalign;
  logic [1:0]  lat_size, lat_off;
  logic        lat_unsigned, lat_reg_wen, lat_write;
  logic [31:0] st_lane_data, ld_data;
  logic [3:0]  st_wstrb;

  assign accept   = in_valid & in_ready;
  assign is_mem   = in_read | in_write;
  // Sizes 2 and 3 both behave as word, so in_size[1] selects the word alignment rule.
  assign misalign = (in_read & in_write)
                  | ((in_size == SZ_H) & in_result[0])
                  | (in_size[1] & (in_result[1:0] != 2'b00));

  ysyx_25020047_lsu_align u_align (
    .st_size      (in_size),
    .st_off       (in_result[1:0]),
    .st_wdata     (in_wdata),
    .st_lane_data (st_lane_data),
    .st_wstrb     (st_wstrb),
    .ld_size      (lat_size),
    .ld_off       (lat_off),
    .ld_unsigned  (lat_unsigned),
    .ld_rdata     (mem_resp_rdata),
    .ld_data      (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (!is_mem || misalign) ? S_DONE : S_REQ;
      S_REQ:  if (mem_req_ready) state_d = S_WAIT;
      S_WAIT: if (mem_resp_valid) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state_q == S_IDLE);
    mem_req_valid = (state_q == S_REQ);
    out_valid     = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_size      <= '0;
      lat_off       <= '0;
      lat_unsigned  <= 1'b0;
      lat_reg_wen   <= 1'b0;
      lat_write     <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      out_data      <= '0;
      out_rd        <= '0;
      out_wen       <= 1'b0;
      out_misalign  <= 1'b0;
    end else begin
      if (accept) begin
        lat_size     <= in_size;
        lat_off      <= in_result[1:0];
        lat_unsigned <= in_unsigned;
        lat_reg_wen  <= in_reg_wen;
        lat_write    <= in_write;
        out_rd       <= in_rd;
        if (!is_mem) begin
          out_data     <= in_result;
          out_wen      <= in_reg_wen;
          out_misalign <= 1'b0;
        end else if (misalign) begin
          out_data     <= '0;
          out_wen      <= 1'b0;
          out_misalign <= 1'b1;
        end else begin
          mem_req_we    <= in_write;
          mem_req_addr  <= {in_result[AW-1:2], 2'b00};
          mem_req_wdata <= st_lane_data;
          mem_req_wstrb <= st_wstrb;
        end
      end
      if (state_q == S_WAIT && mem_resp_valid) begin
        out_data     <= lat_write ? '0 : ld_data;
        out_wen      <= lat_write ? 1'b0 : lat_reg_wen;
        out_misalign <= 1'b0;
      end
      if (state_q == S_DONE && out_ready) out_misalign <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Directed bench for the LSU with a write-back scoreboard and bus-side field checks.
module tb_ysyx_25020047_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_result, in_wdata;
  logic        in_read, in_write, in_unsigned, in_reg_wen;
  logic [1:0]  in_size;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_wen, out_misalign;
  logic [31:0] out_data;
  logic [4:0]  out_rd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic        mis;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ysyx_25020047_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_read(in_read), .in_write(in_write), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_reg_wen(in_reg_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wen(out_wen), .out_misalign(out_misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(
    input string tag, input logic [31:0] res, input logic [4:0] rd, input logic wen,
    input logic [31:0] wd, input logic [1:0] sz, input logic uns,
    input logic rd_f, input logic wr_f, input logic [31:0] rdata,
    input logic exp_mem, input logic [31:0] e_addr, input logic [31:0] e_wdata,
    input logic [3:0] e_wstrb, input int req_stall, input int out_stall,
    input logic [31:0] e_data, input logic e_wen, input logic e_mis, input logic chk_data);
    exp_t e, got;
    bit   seen;
    @(negedge clk);
    check({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_result = res; in_rd = rd; in_reg_wen = wen; in_wdata = wd;
    in_size = sz; in_unsigned = uns; in_read = rd_f; in_write = wr_f;
    e.data = e_data; e.rd = rd; e.wen = e_wen; e.mis = e_mis; e.chk_data = chk_data;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    if (exp_mem) begin
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        if (mem_req_valid) seen = 1'b1;
        else @(negedge clk);
      end
      check({tag, "/req_seen"}, 32'(seen), 32'd1);
      for (int i = 0; i <= req_stall; i++) begin
        check({tag, "/req_valid"}, 32'(mem_req_valid), 32'd1);
        check({tag, "/req_addr"}, mem_req_addr, e_addr);
        check({tag, "/req_we"}, 32'(mem_req_we), 32'(wr_f));
        if (wr_f) begin
          check({tag, "/req_wdata"}, mem_req_wdata, e_wdata);
          check({tag, "/req_wstrb"}, 32'(mem_req_wstrb), 32'(e_wstrb));
        end
        check({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
        if (i < req_stall) @(negedge clk);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check({tag, "/req_dropped"}, 32'(mem_req_valid), 32'd0);
      mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
      @(negedge clk);
      mem_resp_valid = 1'b0;
    end else begin
      check({tag, "/no_req"}, 32'(mem_req_valid), 32'd0);
      check({tag, "/latency1"}, 32'(out_valid), 32'd1);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "/out_seen"}, 32'(seen), 32'd1);
    for (int i = 0; i < out_stall; i++) begin
      check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "/hold_wen"}, 32'(out_wen), 32'(e_wen));
      if (chk_data) check({tag, "/hold_data"}, out_data, e_data);
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      check({tag, "/sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      if (got.chk_data) check({tag, "/out_data"}, out_data, got.data);
      check({tag, "/out_rd"}, 32'(out_rd), 32'(got.rd));
      check({tag, "/out_wen"}, 32'(out_wen), 32'(got.wen));
      check({tag, "/out_misalign"}, 32'(out_misalign), 32'(got.mis));
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/out_cleared"}, 32'(out_valid), 32'd0);
    check({tag, "/misalign_cleared"}, 32'(out_misalign), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_wdata = '0; in_read = 1'b0;
    in_write = 1'b0; in_unsigned = 1'b0; in_reg_wen = 1'b0; in_size = '0; in_rd = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst/in_ready", 32'(in_ready), 32'd1);
    check("rst/req_valid", 32'(mem_req_valid), 32'd0);
    check("rst/req_addr", mem_req_addr, 32'd0);
    check("rst/req_wstrb", 32'(mem_req_wstrb), 32'd0);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/out_data", out_data, 32'd0);
    check("rst/out_misalign", 32'(out_misalign), 32'd0);
    rst_n = 1'b1;

    //    tag      result        rd  wen wdata         sz    u  r  w  rdata         mem addr          wdata         wstrb  rs os exp_data      wen mis chk
    do_op("pass",  32'h00001234, 5,  1, 32'h0,        2'd0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h00001234, 1, 0, 1);
    do_op("lb",    32'h80000003, 7,  1, 32'h0,        2'd0, 0, 1, 0, 32'h80FF0000, 1, 32'h80000000, 32'h0,        4'h0, 0, 0, 32'hFFFFFF80, 1, 0, 1);
    do_op("lbu",   32'h80000003, 8,  1, 32'h0,        2'd0, 1, 1, 0, 32'h80FF0000, 1, 32'h80000000, 32'h0,        4'h0, 0, 0, 32'h00000080, 1, 0, 1);
    do_op("sh_bp", 32'h80000002, 3,  1, 32'hDEADBEEF, 2'd1, 0, 0, 1, 32'h0,        1, 32'h80000000, 32'hBEEFBEEF, 4'hC, 3, 2, 32'h0,        0, 0, 0);
    do_op("lw_mis",32'h80000002, 9,  1, 32'h0,        2'd2, 0, 1, 0, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h0,        0, 1, 0);
    do_op("lh",    32'h10000002, 10, 1, 32'h0,        2'd1, 0, 1, 0, 32'h80011234, 1, 32'h10000000, 32'h0,        4'h0, 1, 1, 32'hFFFF8001, 1, 0, 1);
    do_op("lhu",   32'h10000000, 11, 1, 32'h0,        2'd1, 1, 1, 0, 32'h1234F00D, 1, 32'h10000000, 32'h0,        4'h0, 0, 0, 32'h0000F00D, 1, 0, 1);
    do_op("lw",    32'h10000004, 12, 1, 32'h0,        2'd2, 0, 1, 0, 32'hCAFEF00D, 1, 32'h10000004, 32'h0,        4'h0, 0, 0, 32'hCAFEF00D, 1, 0, 1);
    do_op("sb",    32'h10000001, 0,  0, 32'h000000A5, 2'd0, 0, 0, 1, 32'h0,        1, 32'h10000000, 32'hA5A5A5A5, 4'h2, 0, 0, 32'h0,        0, 0, 0);
    do_op("sw_sz3",32'h10000008, 0,  0, 32'h01234567, 2'd3, 0, 0, 1, 32'h0,        1, 32'h10000008, 32'h01234567, 4'hF, 0, 0, 32'h0,        0, 0, 0);
    do_op("rw_ill",32'h10000000, 13, 1, 32'h0,        2'd2, 0, 1, 1, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h0,        0, 1, 0);
    do_op("sh_mis",32'h10000001, 0,  0, 32'h0,        2'd1, 0, 0, 1, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h0,        0, 1, 0);
    do_op("x0",    32'hFFFFFFFF, 0,  1, 32'h0,        2'd0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 1, 32'hFFFFFFFF, 1, 0, 1);

    // Reset while waiting for a load response, then a late response must be ignored.
    @(negedge clk);
    in_valid = 1'b1; in_result = 32'h20000000; in_read = 1'b1; in_write = 1'b0;
    in_size = 2'd2; in_rd = 5'd14; in_reg_wen = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstw/req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstw/in_ready", 32'(in_ready), 32'd1);
    check("rstw/req_addr", mem_req_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstw/out_valid", 32'(out_valid), 32'd0);
      check("rstw/idle", 32'(in_ready), 32'd1);
      check("rstw/no_req", 32'(mem_req_valid), 32'd0);
      @(negedge clk);
    end

    do_op("post",  32'h0000BEEF, 6,  1, 32'h0,        2'd0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h0000BEEF, 1, 0, 1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25020047_lsu.md
Name: ysyx_25020047_lsu

Overview:
- Load/store unit directly downstream of the execute stage.
- Consumes the execute result (effective address or ALU value), read/write flags, store data and access size.
- Performs at most one data-memory transaction over a valid/ready bus, then hands write-back data to the WBU.
- Non-memory instructions pass through in one cycle. Provides byte-lane alignment, write strobes, load sign/zero extension and misalignment detection.

Parameters:
- AW, 32, address width
- DW, 32, data width (fixed 32; byte lanes = DW/8)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EXU output valid
- in_ready  out  1  LSU can accept
- in_result  in  32  EXU result / effective address
- in_read  in  1  load
- in_write  in  1  store
- in_size  in  2  0=byte, 1=half, 2=word
- in_unsigned  in  1  zero-extend load (lbu/lhu)
- in_wdata  in  32  store data (rs2)
- in_rd  in  5  destination register
- in_reg_wen  in  1  register write enable from EXU
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1=store
- mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_req_wdata  out  32  lane-shifted store data
- mem_req_wstrb  out  4  byte strobes
- mem_resp_valid  in  1  response valid (read data or write ack)
- mem_resp_rdata  in  32  read word
- out_valid  out  1  write-back valid
- out_ready  in  1  WBU accepts
- out_data  out  32  write-back value
- out_rd  out  5  destination register
- out_wen  out  1  register write enable
- out_misalign  out  1  misaligned access flagged (no bus access made)

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wstrb=0; out_valid=0, out_data=0, out_rd=0, out_wen=0, out_misalign=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, in_ready=1; accept on in_valid&in_ready and latch all in_* fields:
  - neither read nor write: go to DONE with out_data=in_result, out_wen=in_reg_wen. Latency 1 cycle.
  - misaligned (half with addr[0]=1, word with addr[1:0]!=0): DONE, out_wen=0, out_misalign=1, no bus request.
  - otherwise: REQ with mem_req_valid=1.
  - read&write both set: treat as illegal, same as misaligned (out_misalign=1).
- REQ: hold mem_req_* stable until mem_req_valid&mem_req_ready; then WAIT. No combinational ready→valid path.
- WAIT: on mem_resp_valid:
  - load: out_data=extended lane; out_wen=latched reg_wen.
  - store: out_wen=0.
  - Go to DONE.
  - A response arriving in the same cycle as acceptance is not legal; the bus returns its response at least 1 cycle after acceptance.
- DONE: out_valid=1, outputs held stable until out_ready; on handshake, clear out_valid/out_misalign and go to IDLE. in_ready=0 in REQ/WAIT/DONE (single outstanding op, no bypass).
- Store lanes:
  - byte: wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - half: wstrb=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - word: 4'b1111, wdata unchanged.
- Load extraction: byte=rdata>>(8*addr[1:0]) [7:0]; half=rdata>>(8*addr[1:0]) [15:0]; sign-extend unless in_unsigned; word unchanged.
- Write-back to x0: pass out_rd=0 unchanged; the regfile ignores it.
- Reset mid-transaction: abandon; any late mem_resp_valid in IDLE is ignored.
- in_size=3: treated as word.

Decomposition:
- Package ysyx_25020047_pkg holds:
  - size encodings SZ_B=0, SZ_H=1, SZ_W=2
  - LSU state enum
  - strobe base constants
- Sub-module ysyx_25020047_lsu_align (combinational) holds store lane/strobe generation and load extraction/extension. The FSM and registers stay in the top.

Test Plan:
- Pass-through: in_result=0x1234, read=write=0, reg_wen=1, rd=5 → out_valid next cycle, out_data=0x1234, out_wen=1, no mem_req_valid.
- lb sign: addr=0x80000003, size=0, rdata=0x80FF_0000 → req_addr=0x80000000, out_data=0xFFFFFF80. Same case as lbu → 0x00000080.
- sh: addr=0x80000002, wdata=0xDEADBEEF → wstrb=4'b1100, req_wdata=0xBEEFBEEF, mem_req_we=1, out_wen=0.
- Backpressure: mem_req_ready low 3 cycles, then out_ready low 2 cycles → mem_req_*/out_* stable throughout, in_ready=0 until out handshake.
- Misalign: lw addr=0x80000002 → no mem_req_valid, out_misalign=1, out_wen=0.
- Reset in WAIT: assert rst_n=0, then pulse mem_resp_valid after release → state IDLE, out_valid stays 0.
